// File: rtl/word_field_packer_pkg.sv
// word_field_packer_pkg
//   Shared defaults, derived field limits and state encoding for the
//   word-to-field packer. The field limits come from a helper function so a
//   parent can override FIELD_W and still get consistent limits.
package word_field_packer_pkg;

    localparam int WORD_W  = 32;
    localparam int FIELD_W = 5;
    localparam int FIELDS  = 6;

    function automatic int field_max(input int fw);
        return (2 ** (fw - 1)) - 1;
    endfunction

    function automatic int field_min(input int fw);
        return -(2 ** (fw - 1));
    endfunction

    localparam int FIELD_MAX = field_max(FIELD_W);
    localparam int FIELD_MIN = field_min(FIELD_W);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/word_field_packer_sat_narrow.sv
// word_field_packer_sat_narrow
//   Narrows one signed WORD_W-bit value to a signed FIELD_W-bit field.
//   Ports:
//     value  in  WORD_W   signed input word
//     field  out FIELD_W  narrowed field (clamped or truncated)
//     sat    out 1        value lay outside the field's signed range
module word_field_packer_sat_narrow
    import word_field_packer_pkg::*;
#(
    parameter int WORD_W   = word_field_packer_pkg::WORD_W,
    parameter int FIELD_W  = word_field_packer_pkg::FIELD_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic [WORD_W-1:0]  value,
    output logic [FIELD_W-1:0] field,
    output logic               sat
);

    localparam int                 F_MAX   = field_max(FIELD_W);
    localparam int                 F_MIN   = field_min(FIELD_W);
    localparam logic [FIELD_W-1:0] MAX_PAT = FIELD_W'(F_MAX);
    localparam logic [FIELD_W-1:0] MIN_PAT = FIELD_W'(F_MIN);

    logic too_big;
    logic too_small;

    always_comb begin
        too_big   = $signed(value) > F_MAX;
        too_small = $signed(value) < F_MIN;
        sat       = too_big | too_small;
        field     = value[FIELD_W-1:0];
        if (SATURATE) begin
            if (too_big) begin
                field = MAX_PAT;
            end else if (too_small) begin
                field = MIN_PAT;
            end
        end
    end

endmodule

// File: rtl/word_field_packer.sv
// word_field_packer
//   Packs up to FIELDS narrowed signed fields into one WORD_W-bit word.
//   Field k sits at bits [k*FIELD_W +: FIELD_W]; unused upper bits are 0.
//   Ports:
//     clock, reset           system clock, synchronous active-high reset
//     in_data/in_valid       signed input word and its valid
//     in_flush               close the current (possibly partial) word
//     in_ready               input accepted this cycle
//     out_data/out_count     packed word and number of valid fields
//     out_sat                some field in out_data was clamped/truncated
//     out_valid/out_ready    output handshake
//
//   state | meaning
//   ACCUM | collecting fields into the pack register, in_ready=1
//   HOLD  | presenting a finished word until out_ready, in_ready=0
module word_field_packer
    import word_field_packer_pkg::*;
#(
    parameter int WORD_W   = word_field_packer_pkg::WORD_W,
    parameter int FIELD_W  = word_field_packer_pkg::FIELD_W,
    parameter int FIELDS   = word_field_packer_pkg::FIELDS,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_flush,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [2:0]        out_count,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                sat_q, sat_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [2:0]          out_count_q, out_count_d;
    logic                out_sat_q, out_sat_d;

    logic [FIELD_W-1:0]  field;
    logic                field_sat;
    logic [WORD_W-1:0]   pack_ins;

    word_field_packer_sat_narrow #(
        .WORD_W   (WORD_W),
        .FIELD_W  (FIELD_W),
        .SATURATE (SATURATE)
    ) u_narrow (
        .value (in_data),
        .field (field),
        .sat   (field_sat)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pack_d      = pack_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        in_ready    = (state_q == ACCUM);
        out_valid   = (state_q == HOLD);
        // Slot idx is always zero in pack_q, so OR-ing the new field in is safe.
        pack_ins    = pack_q | ({{(WORD_W-FIELD_W){1'b0}}, field} << (idx_q * FIELD_W));

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (idx_q == 3'(FIELDS - 1) || in_flush) begin
                        out_data_d  = pack_ins;
                        out_count_d = idx_q + 3'd1;
                        out_sat_d   = sat_q | field_sat;
                        pack_d      = '0;
                        idx_d       = '0;
                        sat_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        pack_d = pack_ins;
                        idx_d  = idx_q + 3'd1;
                        sat_d  = sat_q | field_sat;
                    end
                end else if (in_flush && idx_q != 3'd0) begin
                    // A flush with nothing collected is dropped: never emit an empty word.
                    out_data_d  = pack_q;
                    out_count_d = idx_q;
                    out_sat_d   = sat_q;
                    pack_d      = '0;
                    idx_d       = '0;
                    sat_d       = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            pack_q      <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pack_q      <= pack_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_word_field_packer.sv
// tb_word_field_packer
//   Two packers (clamping and truncating) driven in lockstep, checked every
//   cycle against a transaction-level model plus directed literal checks.
module tb_word_field_packer;

    localparam int FIELDS = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1;
    logic [31:0] o_data0, o_data1;
    logic [2:0]  o_count0, o_count1;
    logic        o_sat0, o_sat1;
    logic        o_valid0, o_valid1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    word_field_packer #(.SATURATE(1'b1)) u_sat (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_flush(in_flush), .in_ready(in_ready0), .out_data(o_data0),
        .out_count(o_count0), .out_sat(o_sat0), .out_valid(o_valid0),
        .out_ready(out_ready)
    );

    word_field_packer #(.SATURATE(1'b0)) u_trunc (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_flush(in_flush), .in_ready(in_ready1), .out_data(o_data1),
        .out_count(o_count1), .out_sat(o_sat1), .out_valid(o_valid1),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_fields[$];
    bit          m_hold = 1'b0;
    logic [31:0] e_data0, e_data1;
    int          e_count;
    bit          e_sat0, e_sat1;

    function automatic int field_bits(input int v, input bit clamp);
        if (clamp && v > 15) return 15;
        if (clamp && v < -16) return 16;
        return v & 31;
    endfunction

    task automatic m_emit();
        e_data0 = '0;
        e_data1 = '0;
        e_sat0  = 1'b0;
        foreach (m_fields[k]) begin
            e_data0 = e_data0 | (32'(field_bits(m_fields[k], 1'b1)) << (5 * k));
            e_data1 = e_data1 | (32'(field_bits(m_fields[k], 1'b0)) << (5 * k));
            if (m_fields[k] > 15 || m_fields[k] < -16) e_sat0 = 1'b1;
        end
        e_sat1  = e_sat0;
        e_count = m_fields.size();
        m_fields.delete();
        m_hold = 1'b1;
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_fields.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            m_fields.push_back(int'($signed(in_data)));
            if (m_fields.size() == FIELDS || in_flush) m_emit();
        end else if (in_flush && m_fields.size() > 0) begin
            m_emit();
        end
    end

    // ---------------- per-cycle compare + word capture ----------------
    int          words = 0;
    bit          prev_valid = 1'b0;
    logic [31:0] last0_data, last1_data;
    logic [2:0]  last_count;
    logic        last0_sat, last1_sat;

    always @(negedge clock) begin
        if (chk_en) begin
            check("valid_sat", {31'b0, o_valid0}, {31'b0, m_hold});
            check("valid_trunc", {31'b0, o_valid1}, {31'b0, m_hold});
            check("ready_sat", {31'b0, in_ready0}, {31'b0, !m_hold});
            check("ready_trunc", {31'b0, in_ready1}, {31'b0, !m_hold});
            if (m_hold) begin
                check("data_sat", o_data0, e_data0);
                check("data_trunc", o_data1, e_data1);
                check("count_sat", {29'b0, o_count0}, 32'(e_count));
                check("count_trunc", {29'b0, o_count1}, 32'(e_count));
                check("flag_sat", {31'b0, o_sat0}, {31'b0, e_sat0});
                check("flag_trunc", {31'b0, o_sat1}, {31'b0, e_sat1});
            end
            if (o_valid0 && !prev_valid) begin
                words++;
                last0_data = o_data0;
                last1_data = o_data1;
                last_count = o_count0;
                last0_sat  = o_sat0;
                last1_sat  = o_sat1;
            end
        end
        prev_valid = o_valid0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int d, input bit f);
        bit ok;
        in_valid = 1'b1;
        in_data  = 32'(d);
        in_flush = f;
        for (int i = 0; i < 40; i++) begin
            ok = in_ready0;
            cycle();
            if (ok) begin
                in_valid = 1'b0;
                in_flush = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
        check("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_word(input int base);
        for (int i = 0; i < 30; i++) begin
            if (words > base) return;
            @(negedge clock);
            #1;
        end
        check("word_timeout", 32'(words), 32'(base + 1));
    endtask

    task automatic push_seq(input int a, input int b, input int c,
                            input int d, input int e, input int f);
        push(a, 1'b0); push(b, 1'b0); push(c, 1'b0);
        push(d, 1'b0); push(e, 1'b0); push(f, 1'b0);
    endtask

    int base;

    initial begin
        reset = 1'b1;
        cycle();
        cycle();
        chk_en = 1'b1;
        @(negedge clock);
        check("rst_valid", {31'b0, o_valid0}, 32'd0);
        check("rst_ready", {31'b0, in_ready0}, 32'd1);
        check("rst_data", o_data0, 32'd0);
        check("rst_count", {29'b0, o_count0}, 32'd0);
        check("rst_sat", {31'b0, o_sat0}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;

        // full word 0..5, then one-cycle ready bubble
        base = words;
        push_seq(0, 1, 2, 3, 4, 5);
        check("bubble_low", {31'b0, in_ready0}, 32'd0);
        cycle();
        check("bubble_back", {31'b0, in_ready0}, 32'd1);
        wait_word(base);
        check("full_data", last0_data, 32'h0A418820);
        check("full_count", {29'b0, last_count}, 32'd6);
        check("full_sat", {31'b0, last0_sat}, 32'd0);

        base = words;
        push_seq(1, 2, 3, 4, 5, 6);
        wait_word(base);
        check("w16_data", last0_data, 32'h0C520C41);

        // clamping vs truncation of out-of-range values
        base = words;
        push_seq(100, -100, 15, -16, 0, 0);
        wait_word(base);
        check("sat_data", last0_data, 32'h00083E0F);
        check("sat_flag", {31'b0, last0_sat}, 32'd1);
        check("trunc_data", last1_data, 32'h00083F84);

        base = words;
        push_seq(1, 2, 3, 4, 5, 6);
        wait_word(base);
        check("sat_cleared", {31'b0, last0_sat}, 32'd0);

        base = words;
        push_seq(32'h23, 0, 0, 0, 0, 0);
        wait_word(base);
        check("trunc_f0", last1_data, 32'h00000003);
        check("trunc_flag", {31'b0, last1_sat}, 32'd1);
        check("clamp_f0", last0_data, 32'h0000000F);

        // flush with data, flush alone at idx 0, flush alone at idx 2
        base = words;
        push(7, 1'b0); push(8, 1'b0); push(9, 1'b1);
        wait_word(base);
        check("flush_count", {29'b0, last_count}, 32'd3);
        check("flush_data", last0_data, 32'h00002507);

        repeat (2) cycle();
        base = words;
        in_flush = 1'b1;
        cycle();
        in_flush = 1'b0;
        repeat (4) cycle();
        check("empty_flush", 32'(words), 32'(base));

        base = words;
        push(3, 1'b0); push(4, 1'b0);
        in_flush = 1'b1;
        cycle();
        in_flush = 1'b0;
        wait_word(base);
        check("partial_count", {29'b0, last_count}, 32'd2);
        check("partial_data", last0_data, 32'h00000083);

        // backpressure
        repeat (2) cycle();
        out_ready = 1'b0;
        base = words;
        push_seq(1, 2, 3, 4, 5, 6);
        in_valid = 1'b1;
        in_data  = 32'd9;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_ready", {31'b0, in_ready0}, 32'd0);
            check("bp_data", o_data0, 32'h0C520C41);
        end
        out_ready = 1'b1;
        base = words;
        push(9, 1'b0); push(10, 1'b0); push(11, 1'b0);
        push(12, 1'b0); push(13, 1'b0); push(14, 1'b0);
        wait_word(base);
        check("bp_next", last0_data,
              32'(9 + (10 << 5) + (11 << 10) + (12 << 15) + (13 << 20) + (14 << 25)));

        // reset mid-accumulation
        repeat (2) cycle();
        push(1, 1'b0); push(2, 1'b0); push(3, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_valid", {31'b0, o_valid0}, 32'd0);
        base = words;
        push_seq(1, 2, 3, 4, 5, 6);
        wait_word(base);
        check("mid_rst_data", last0_data, 32'h0C520C41);
        check("mid_rst_count", {29'b0, last_count}, 32'd6);

        // reset while holding
        repeat (2) cycle();
        out_ready = 1'b0;
        base = words;
        push_seq(6, 5, 4, 3, 2, 1);
        wait_word(base);
        check("hold_valid", {31'b0, o_valid0}, 32'd1);
        reset = 1'b1;
        cycle();
        check("hold_rst_valid", {31'b0, o_valid0}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_flush  = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0: in_data = 32'(int'($urandom_range(0, 31)) - 16);
                1: case ($urandom_range(0, 3))
                       0: in_data = 32'd15;
                       1: in_data = 32'd16;
                       2: in_data = 32'hFFFFFFF0;
                       default: in_data = 32'hFFFFFFEF;
                   endcase
                2: in_data = 32'(int'($urandom_range(0, 80)) - 40);
                default: in_data = $urandom;
            endcase
            cycle();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        in_flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
